axis_pkt_mux: RTL and testbench
===============================

AXIS_PKT_MUX -- requirements
Module: axis_pkt_mux

Interface
REQ-001 SHALL have parameter DATA_W, default 8: tdata width in bits.
REQ-002 SHALL have parameter N_CH, default 4: input channel count, range 2..16.
REQ-003 SHALL have parameter ARB_MODE, default 0: 0 = packet-locked external select, 1 = round-robin.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port sel, input, SEL_W = clog2(N_CH): channel request, used only when ARB_MODE=0.
REQ-007 SHALL have port input_tdata, input, N_CH*DATA_W: channel k at bits [k*DATA_W +: DATA_W].
REQ-008 SHALL have ports input_tvalid, input_tlast (inputs) and input_tready (output), each N_CH wide: per-channel handshake.
REQ-009 SHALL have ports output_data (output, DATA_W), output_valid (output, 1), output_last (output, 1) and output_ready (input, 1).
REQ-010 SHALL have port active_ch, output, SEL_W: currently granted channel.
REQ-011 SHALL have port busy, output, 1: high while a packet is locked.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and PKT.
REQ-013 In IDLE with ARB_MODE=0, the block SHALL grant channel sel when sel < N_CH and input_tvalid[sel]=1; otherwise it SHALL stay in IDLE.
REQ-014 In IDLE with ARB_MODE=1, the block SHALL grant the first valid channel searching upward from rr_ptr+1, modulo N_CH.
REQ-015 On a grant, active_ch SHALL register the granted index, the FSM SHALL enter PKT on the next edge, and busy SHALL go high.
REQ-016 In PKT, input_tready[active_ch] SHALL equal (!output_valid || output_ready), and every other input_tready bit SHALL be 0.
REQ-017 No input_tready bit SHALL be high in IDLE.
REQ-018 The output stage SHALL be a single register stage: an accepted beat appears on output_data/output_last one cycle after acceptance, with output_valid=1.
REQ-019 output_valid SHALL fall when output_ready=1 and no new beat is accepted in the same cycle.
REQ-020 Registered output contents SHALL be held stable while output_valid=1 and output_ready=0.
REQ-021 An accepted beat with tlast=1 SHALL return the FSM to IDLE on the next edge; in ARB_MODE=1 it SHALL also set rr_ptr to active_ch.
REQ-022 Changes on sel during PKT SHALL be ignored; the grant is locked until the tlast beat is accepted.
REQ-023 A single-beat packet (first beat carrying tlast) SHALL take exactly one PKT cycle when output_ready=1.
REQ-024 Back-to-back packets SHALL incur exactly one IDLE bubble cycle between the tlast acceptance and the next packet's first acceptance.
REQ-025 Latency from input_tvalid rising in IDLE to output_valid SHALL be 2 cycles when output_ready=1.

Reset
REQ-026 While reset_n=0, the block SHALL clear state to IDLE, output_valid to 0, output_data to 0, output_last to 0, active_ch to 0, busy to 0, rr_ptr to N_CH-1 and input_tready to 0.
REQ-027 Reset asserted mid-packet SHALL discard any partial packet; after release the block SHALL re-arbitrate from IDLE.

Structure
REQ-028 A shared package axis_mux_pkg SHALL hold the FSM state enum and the ARB_MODE constants (ARB_SELECT, ARB_RR).
REQ-029 Round-robin search SHALL live in one sub-module, rr_arbiter, parametrised by N_CH (inputs req and ptr; outputs grant_idx and grant_vld).
REQ-030 Select mode SHALL bypass rr_arbiter.

Verification
REQ-031 Select scenario: ARB_MODE=0, N_CH=4, sel=2, ch2 sends 3 beats AA,BB,CC (tlast on CC) -> output_data AA,BB,CC; output_last only on CC; other input_tready bits always 0.
REQ-032 Lock scenario: sel changes 2->1 after the first beat -> remaining ch2 beats still forwarded; ch1 granted only after the CC tlast plus one IDLE cycle.
REQ-033 Round-robin scenario: ARB_MODE=1, all 4 channels hold 1-beat packets 10,11,12,13 -> output order ch0,ch1,ch2,ch3,ch0.
REQ-034 Backpressure scenario: output_ready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; output_data stable while stalled.
REQ-035 Reset scenario: reset_n pulled low after 2 of 4 beats -> output_valid=0 and busy=0 asynchronously; the next packet after release is forwarded intact.
REQ-036 Invalid-select scenario: sel=3 with input_tvalid[3]=0 -> FSM stays IDLE, busy=0, no output.

Source files
------------

// File: rtl/axis_mux_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_mux_pkg : shared FSM state encoding and arbitration mode codes  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package axis_mux_pkg;

    localparam int ARB_SELECT = 0;
    localparam int ARB_RR     = 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } mux_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_pkt_mux_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_pkt_mux_if : N-channel AXI-Stream input bundle + single output  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface axis_pkt_mux_if #(
    parameter int DATA_W = 8,
    parameter int N_CH   = 4
);
    logic [N_CH*DATA_W-1:0] input_tdata;
    logic [N_CH-1:0]        input_tvalid;
    logic [N_CH-1:0]        input_tlast;
    logic [N_CH-1:0]        input_tready;
    logic [DATA_W-1:0]      output_data;
    logic                   output_valid;
    logic                   output_last;
    logic                   output_ready;

    // Mux-side view: consumes the channels, sources the output stream.
    modport slave (
        input  input_tdata, input_tvalid, input_tlast,
        output input_tready,
        output output_data, output_valid, output_last,
        input  output_ready
    );

    modport master (
        output input_tdata, input_tvalid, input_tlast,
        input  input_tready,
        input  output_data, output_valid, output_last,
        output output_ready
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : first requester at or above ptr+1, wrapping modulo N_CH |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N_CH  = 4,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  wire [N_CH-1:0]  req,
    input  wire [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    logic [SEL_W-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        w_idx     = '0;
        for (int off = N_CH; off >= 1; off--) begin
            w_idx = SEL_W'((int'(ptr) + off) % N_CH);
            if (req[w_idx]) begin
                grant_vld = 1'b1;
                grant_idx = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axis_pkt_mux : packet-locked N:1 AXI-Stream mux, registered output   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module axis_pkt_mux
    import axis_mux_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int N_CH     = 4,
    parameter int ARB_MODE = ARB_SELECT,
    parameter int SEL_W    = $clog2(N_CH)
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire [SEL_W-1:0]  sel,
    axis_pkt_mux_if.slave    bus,
    output logic [SEL_W-1:0] active_ch,
    output logic             busy
);

    mux_state_t        r_state;
    mux_state_t        w_state_nxt;
    logic [SEL_W-1:0]  r_active_ch;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_out_valid;

    logic              w_grant_vld;
    logic [SEL_W-1:0]  w_grant_idx;
    logic              w_load_grant;
    logic              w_out_free;
    logic              w_accept;
    logic              w_pkt_done;
    logic [N_CH-1:0]   w_tready;

    // The output register can take a beat when empty or draining this cycle.
    assign w_out_free = !r_out_valid || bus.output_ready;

    generate
        if (ARB_MODE == ARB_RR) begin : g_rr
            logic [SEL_W-1:0] r_rr_ptr;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_rr_ptr <= SEL_W'(N_CH - 1);
                end else if (w_pkt_done) begin
                    r_rr_ptr <= r_active_ch;
                end
            end

            rr_arbiter #(
                .N_CH  (N_CH),
                .SEL_W (SEL_W)
            ) u_rr_arbiter (
                .req       (bus.input_tvalid),
                .ptr       (r_rr_ptr),
                .grant_idx (w_grant_idx),
                .grant_vld (w_grant_vld)
            );
        end else begin : g_sel
            assign w_grant_vld = ({1'b0, sel} < (SEL_W + 1)'(N_CH)) && bus.input_tvalid[sel];
            assign w_grant_idx = sel;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_grant = 1'b0;
        w_accept     = 1'b0;
        w_pkt_done   = 1'b0;
        w_tready     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_load_grant = 1'b1;
                    w_state_nxt  = ST_PKT;
                end
            end
            ST_PKT: begin
                for (int k = 0; k < N_CH; k++) begin
                    w_tready[k] = (r_active_ch == SEL_W'(k)) && w_out_free;
                end
                w_accept   = bus.input_tvalid[r_active_ch] && w_out_free;
                w_pkt_done = w_accept && bus.input_tlast[r_active_ch];
                if (w_pkt_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active_ch <= '0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_load_grant) begin
                r_active_ch <= w_grant_idx;
            end
            if (w_accept) begin
                r_out_data  <= bus.input_tdata[int'(r_active_ch) * DATA_W +: DATA_W];
                r_out_last  <= bus.input_tlast[r_active_ch];
                r_out_valid <= 1'b1;
            end else if (bus.output_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.input_tready = w_tready;
    assign bus.output_data  = r_out_data;
    assign bus.output_last  = r_out_last;
    assign bus.output_valid = r_out_valid;
    assign active_ch        = r_active_ch;
    assign busy             = (r_state == ST_PKT);

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_mux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axis_pkt_mux : scoreboard bench, select-mode and round-robin DUTs |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_axis_pkt_mux;
    import axis_mux_pkg::*;

    localparam int DATA_W = 8;
    localparam int N_CH   = 4;
    localparam int SEL_W  = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [SEL_W-1:0] sel0, sel1;
    logic [SEL_W-1:0] act0, act1;
    logic             busy0, busy1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int acc0     = 0;
    int cf, cl, cf1, cl1, lock_base;

    logic [N_CH-1:0] allowed0;
    logic [8:0]      q0[$];
    logic [8:0]      q1[$];

    axis_pkt_mux_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus0();
    axis_pkt_mux_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus1();

    axis_pkt_mux #(.DATA_W(DATA_W), .N_CH(N_CH), .ARB_MODE(ARB_SELECT)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .sel(sel0), .bus(bus0),
        .active_ch(act0), .busy(busy0)
    );

    axis_pkt_mux #(.DATA_W(DATA_W), .N_CH(N_CH), .ARB_MODE(ARB_RR)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .sel(sel1), .bus(bus1),
        .active_ch(act1), .busy(busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output-side scoreboards; stalled outputs must match the pending head.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk_eq("tready_mask0", 32'(bus0.input_tready & ~allowed0), 32'd0);
            if (!busy0) chk_eq("tready_idle0", 32'(bus0.input_tready), 32'd0);
            if (bus0.output_valid) begin
                if (q0.size() == 0) begin
                    chk_eq("sb0_unexpected", 32'd1, 32'd0);
                end else begin
                    chk_eq(bus0.output_ready ? "out0" : "stall0",
                           32'({bus0.output_last, bus0.output_data}), 32'(q0[0]));
                    if (bus0.output_ready) void'(q0.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (!busy1) chk_eq("tready_idle1", 32'(bus1.input_tready), 32'd0);
            if (bus1.output_valid) begin
                if (q1.size() == 0) begin
                    chk_eq("sb1_unexpected", 32'd1, 32'd0);
                end else begin
                    chk_eq("out1", 32'({bus1.output_last, bus1.output_data}), 32'(q1[0]));
                    if (bus1.output_ready) void'(q1.pop_front());
                end
            end
        end
    end

    task automatic send0(input int ch, input int n, input logic [31:0] w, input bit term,
                         input bit own, output int c_first, output int c_last);
        int         t;
        logic [8:0] exp;
        c_first = -1;
        c_last  = -1;
        if (own) begin
            allowed0     = '0;
            allowed0[ch] = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            bus0.input_tdata[ch*DATA_W +: DATA_W] = w[i*8 +: 8];
            bus0.input_tlast[ch]  = term && (i == n - 1);
            bus0.input_tvalid[ch] = 1'b1;
            t = 0;
            @(negedge clk);
            while (!bus0.input_tready[ch] && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk_eq("accept0", 32'(bus0.input_tready[ch]), 32'd1);
            if (!bus0.input_tready[ch]) break;
            exp = {term && (i == n - 1), w[i*8 +: 8]};
            q0.push_back(exp);
            acc0++;
            chk_eq("busy_acc0", 32'(busy0), 32'd1);
            chk_eq("act0", 32'(act0), 32'(ch));
            if (i == 0) c_first = cyc;
            c_last = cyc;
            @(posedge clk);
            #1;
        end
        bus0.input_tvalid[ch] = 1'b0;
        bus0.input_tlast[ch]  = 1'b0;
    endtask

    task automatic drain(input bit which);
        int t = 0;
        while (((which ? q1.size() : q0.size()) != 0) && t < 50) begin
            @(posedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk_eq(which ? "drain1" : "drain0", 32'(which ? q1.size() : q0.size()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        int rr_cyc[5];
        int t;
        order = '{0, 1, 2, 3, 0};
        reset_n  = 1'b0;
        sel0     = '0;
        sel1     = '0;
        allowed0 = '0;
        bus0.input_tdata = '0; bus0.input_tvalid = '0; bus0.input_tlast = '0; bus0.output_ready = 1'b1;
        bus1.input_tdata = '0; bus1.input_tvalid = '0; bus1.input_tlast = '0; bus1.output_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_valid0", 32'(bus0.output_valid), 32'd0);
        chk_eq("rst_data0",  32'(bus0.output_data), 32'd0);
        chk_eq("rst_last0",  32'(bus0.output_last), 32'd0);
        chk_eq("rst_act0",   32'(act0), 32'd0);
        chk_eq("rst_busy0",  32'(busy0), 32'd0);
        chk_eq("rst_tready0", 32'(bus0.input_tready), 32'd0);
        chk_eq("rst_valid1", 32'(bus1.output_valid), 32'd0);
        chk_eq("rst_act1",   32'(act1), 32'd0);
        chk_eq("rst_busy1",  32'(busy1), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Select: ch2 sends AA,BB,CC; first output two edges after tvalid.
        sel0 = 2'd2;
        fork
            send0(2, 3, 32'h00CCBBAA, 1'b1, 1'b1, cf, cl);
            begin
                int n = 0;
                while (!bus0.output_valid && n < 10) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk_eq("latency0", 32'(n), 32'd2);
            end
        join
        drain(1'b0);

        // Lock: sel moves to 1 after the first beat; ch1 waits for tlast + bubble.
        sel0      = 2'd2;
        lock_base = acc0;
        fork
            begin
                send0(2, 3, 32'h00CCBBAA, 1'b1, 1'b1, cf, cl);
                allowed0 = 4'b0010;
            end
            send0(1, 1, 32'h000000DD, 1'b1, 1'b0, cf1, cl1);
            begin
                t = 0;
                while (acc0 < lock_base + 1 && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                @(posedge clk);
                #1;
                sel0 = 2'd1;
            end
        join
        chk_eq("lock_gap", 32'(cf1 - cl), 32'd2);
        drain(1'b0);

        // Backpressure: output_ready pattern 1,0,0,1 repeating over a 4-beat packet.
        sel0 = 2'd0;
        fork
            send0(0, 4, 32'h04030201, 1'b1, 1'b1, cf, cl);
            begin
                for (int k = 0; k < 12; k++) begin
                    bus0.output_ready = (k % 4 == 0) || (k % 4 == 3);
                    @(posedge clk);
                    #1;
                end
                bus0.output_ready = 1'b1;
            end
        join
        drain(1'b0);

        // Reset mid-packet after 2 of 4 beats.
        sel0 = 2'd3;
        send0(3, 2, 32'h00002211, 1'b0, 1'b1, cf, cl);
        #2;
        reset_n = 1'b0;
        #1;
        chk_eq("arst_valid0", 32'(bus0.output_valid), 32'd0);
        chk_eq("arst_busy0",  32'(busy0), 32'd0);
        chk_eq("arst_tready0", 32'(bus0.input_tready), 32'd0);
        q0.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        send0(3, 4, 32'h88776655, 1'b1, 1'b1, cf, cl);
        drain(1'b0);

        // Invalid select: sel=3 idle while only ch0 is valid.
        allowed0 = '0;
        sel0 = 2'd3;
        bus0.input_tdata[7:0] = 8'h5A;
        bus0.input_tvalid[0]  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk_eq("inv_busy0",  32'(busy0), 32'd0);
            chk_eq("inv_valid0", 32'(bus0.output_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        bus0.input_tvalid[0] = 1'b0;

        // Round-robin: all channels hold single-beat packets 10..13.
        bus1.input_tdata  = 32'h13121110;
        bus1.input_tlast  = '1;
        bus1.input_tvalid = '1;
        for (int k = 0; k < 5; k++) begin
            t = 0;
            @(negedge clk);
            while (!(|bus1.input_tready) && t < 20) begin
                @(negedge clk);
                t++;
            end
            chk_eq("rr_grant", 32'(bus1.input_tready), 32'd1 << order[k]);
            q1.push_back({1'b1, 8'(8'h10 + order[k])});
            rr_cyc[k] = cyc;
            if (k > 0) chk_eq("rr_gap", 32'(rr_cyc[k] - rr_cyc[k-1]), 32'd2);
            @(posedge clk);
            #1;
        end
        bus1.input_tvalid = '0;
        drain(1'b1);

        chk_eq("sb0_left", 32'(q0.size()), 32'd0);
        chk_eq("sb1_left", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
